// File: rtl/stopwatch_controller_pkg.sv
// Shared definitions for the stopwatch controller: FSM encoding and count limits.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package stopwatch_controller_pkg;

  // Encoding is visible on state_o, so the values are fixed.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_SPLIT = 2'd2,
    ST_PAUSE = 2'd3
  } sw_state_e;

  localparam logic [15:0] MAX_CNT_DEFAULT = 16'h9999;

  // RUN and SPLIT both let the counter advance; only the display source differs.
  function automatic logic is_counting(input sw_state_e s);
    return (s == ST_RUN) || (s == ST_SPLIT);
  endfunction

endpackage

// File: rtl/stopwatch_controller_edge_detect.sv
// Rising-edge detector: one pulse per low-to-high transition of a debounced level.
// Latency: pulse is combinational in the cycle the input is first seen high.
// Backpressure: none; holding the input high produces no further pulses.
//
// Ports:
//   clk_i   - system clock, rising edge
//   rst_i   - synchronous active-low reset (history cleared to 0)
//   d_i     - debounced button level
//   pulse_o - high for the single cycle where d_i is high and its history is low
module edge_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic pulse_o
);

  logic hist_q;
  logic hist_d;

  always_comb begin
    hist_d = d_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      hist_q <= 1'b0;
    end else begin
      hist_q <= hist_d;
    end
  end

  assign pulse_o = d_i & ~hist_q;

endmodule

// File: rtl/stopwatch_controller.sv
// Stopwatch sequencer: buttons -> counter enable/clear strobes, lap capture, display select, blink.
// Latency: cnt_en_o/cnt_clr_o/state_o change 1 cycle after the tick or button edge; disp_o is combinational.
// Backpressure: none; ticks that coincide with start/clr edges or arrive at saturation are dropped.
//
// Ports:
//   clk_i      - system clock, rising edge
//   rst_i      - synchronous active-low reset
//   tick_i     - single-cycle count strobe from the clock divider
//   start_i    - debounced start/pause button level
//   lap_i      - debounced lap button level
//   clr_i      - debounced clear button level
//   cnt_i      - BCD count fed back from the counter
//   cnt_en_o   - counter enable, one pulse per accepted tick
//   cnt_clr_o  - counter synchronous clear pulse
//   disp_o     - digits to the display (live count or lap register)
//   blank_o    - display blank request while paused
//   ovf_o      - sticky saturation flag
//   state_o    - current FSM state
module stopwatch_controller
  import stopwatch_controller_pkg::*;
#(
  parameter int                  DIGITS      = 4,
  parameter logic [4*DIGITS-1:0] MAX_CNT     = (4*DIGITS)'(MAX_CNT_DEFAULT),
  parameter int                  BLINK_TICKS = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                tick_i,
  input  logic                start_i,
  input  logic                lap_i,
  input  logic                clr_i,
  input  logic [4*DIGITS-1:0] cnt_i,
  output logic                cnt_en_o,
  output logic                cnt_clr_o,
  output logic [4*DIGITS-1:0] disp_o,
  output logic                blank_o,
  output logic                ovf_o,
  output logic [1:0]          state_o
);

  localparam int              BW         = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [BW-1:0]   BLINK_LAST = BW'(BLINK_TICKS - 1);

  logic start_evt;
  logic lap_evt;
  logic clr_evt;

  edge_detect u_start_ed (.clk_i(clk_i), .rst_i(rst_i), .d_i(start_i), .pulse_o(start_evt));
  edge_detect u_lap_ed   (.clk_i(clk_i), .rst_i(rst_i), .d_i(lap_i),   .pulse_o(lap_evt));
  edge_detect u_clr_ed   (.clk_i(clk_i), .rst_i(rst_i), .d_i(clr_i),   .pulse_o(clr_evt));

  sw_state_e           state_q,     state_d;
  logic [4*DIGITS-1:0] lap_q,       lap_d;
  logic                keep_lap_q,  keep_lap_d;   // PAUSE was entered from SPLIT
  logic                ovf_q,       ovf_d;
  logic                blank_q,     blank_d;
  logic [BW-1:0]       blink_cnt_q, blink_cnt_d;
  logic                cnt_en_q,    cnt_en_d;
  logic                cnt_clr_q,   cnt_clr_d;

  logic counting;
  logic at_max;

  always_comb begin
    state_d     = state_q;
    lap_d       = lap_q;
    keep_lap_d  = keep_lap_q;
    ovf_d       = ovf_q;
    blank_d     = blank_q;
    blink_cnt_d = blink_cnt_q;
    cnt_en_d    = 1'b0;
    cnt_clr_d   = 1'b0;

    counting = is_counting(state_q);
    at_max   = (cnt_i == MAX_CNT);

    if (clr_evt) begin
      state_d    = ST_IDLE;
      cnt_clr_d  = 1'b1;
      lap_d      = '0;
      ovf_d      = 1'b0;
      keep_lap_d = 1'b0;
    end else if (start_evt) begin
      // Start/pause toggle; the coincident tick is intentionally not counted.
      case (state_q)
        ST_IDLE:  state_d = ST_RUN;
        ST_RUN: begin
          state_d    = ST_PAUSE;
          keep_lap_d = 1'b0;
        end
        ST_SPLIT: begin
          state_d    = ST_PAUSE;
          keep_lap_d = 1'b1;
        end
        default:  state_d = ST_RUN;
      endcase
    end else if (counting && tick_i && at_max) begin
      // Saturation: freeze instead of wrapping, keep whichever digits were shown.
      ovf_d      = 1'b1;
      state_d    = ST_PAUSE;
      keep_lap_d = (state_q == ST_SPLIT);
    end else begin
      cnt_en_d = counting && tick_i;
      if (lap_evt) begin
        case (state_q)
          ST_RUN: begin
            lap_d   = cnt_i;
            state_d = ST_SPLIT;
          end
          ST_SPLIT: state_d = ST_RUN;
          ST_PAUSE: begin
            // Lap while paused doubles as a reset of the whole stopwatch.
            state_d    = ST_IDLE;
            cnt_clr_d  = 1'b1;
            lap_d      = '0;
            ovf_d      = 1'b0;
            keep_lap_d = 1'b0;
          end
          default: ;
        endcase
      end else if ((state_q == ST_PAUSE) && tick_i) begin
        if (blink_cnt_q == BLINK_LAST) begin
          blank_d     = ~blank_q;
          blink_cnt_d = '0;
        end else begin
          blink_cnt_d = blink_cnt_q + 1'b1;
        end
      end
    end

    // Blink state only lives inside PAUSE; any exit restarts it unblanked.
    if (state_d != ST_PAUSE) begin
      blank_d     = 1'b0;
      blink_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      lap_q       <= '0;
      keep_lap_q  <= 1'b0;
      ovf_q       <= 1'b0;
      blank_q     <= 1'b0;
      blink_cnt_q <= '0;
      cnt_en_q    <= 1'b0;
      cnt_clr_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      lap_q       <= lap_d;
      keep_lap_q  <= keep_lap_d;
      ovf_q       <= ovf_d;
      blank_q     <= blank_d;
      blink_cnt_q <= blink_cnt_d;
      cnt_en_q    <= cnt_en_d;
      cnt_clr_q   <= cnt_clr_d;
    end
  end

  assign cnt_en_o  = cnt_en_q;
  assign cnt_clr_o = cnt_clr_q;
  assign blank_o   = blank_q;
  assign ovf_o     = ovf_q;
  assign state_o   = state_q;
  assign disp_o    = ((state_q == ST_SPLIT) || ((state_q == ST_PAUSE) && keep_lap_q)) ? lap_q : cnt_i;

endmodule

// File: tb/tb_stopwatch_controller.sv
// Bench for the stopwatch sequencer with a behavioural stopwatch and BCD counter model.
// Latency: expected outputs are queued one cycle ahead and popped after every clock edge.
// Backpressure: n/a.
module tb_stopwatch_controller;

  localparam int BLINK = 1;
  localparam int M_IDLE = 0, M_RUN = 1, M_SPLIT = 2, M_PAUSE = 3;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        tick_i = 1'b0;
  logic        start_i = 1'b0;
  logic        lap_i = 1'b0;
  logic        clr_i = 1'b0;
  logic [15:0] cnt_i = 16'h0000;
  logic        cnt_en_o;
  logic        cnt_clr_o;
  logic [15:0] disp_o;
  logic        blank_o;
  logic        ovf_o;
  logic [1:0]  state_o;

  always #5 clk_i = ~clk_i;

  stopwatch_controller #(
    .DIGITS(4),
    .MAX_CNT(16'h9999),
    .BLINK_TICKS(BLINK)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .tick_i(tick_i),
    .start_i(start_i),
    .lap_i(lap_i),
    .clr_i(clr_i),
    .cnt_i(cnt_i),
    .cnt_en_o(cnt_en_o),
    .cnt_clr_o(cnt_clr_o),
    .disp_o(disp_o),
    .blank_o(blank_o),
    .ovf_o(ovf_o),
    .state_o(state_o)
  );

  typedef struct {
    logic [1:0]  st;
    logic        en;
    logic        clr;
    logic        ovf;
    logic        blank;
    logic [15:0] disp;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  // Stimulus levels held between steps.
  bit r_n = 1'b0;
  bit bs  = 1'b0;
  bit bl  = 1'b0;
  bit bc  = 1'b0;

  // Reference model: user-visible stopwatch behaviour plus the external counter.
  int          m_mode  = M_IDLE;
  logic [15:0] m_lap   = 16'h0;
  bit          m_keep  = 1'b0;
  bit          m_ovf   = 1'b0;
  bit          m_blank = 1'b0;
  int          m_bt    = 0;
  bit          h_s = 1'b0, h_l = 1'b0, h_c = 1'b0;
  bit          en_out  = 1'b0;
  bit          clr_out = 1'b0;
  logic [15:0] m_cnt   = 16'h0;

  function automatic logic [15:0] bcd_inc(input logic [15:0] x);
    int v;
    v = int'(x[15:12]) * 1000 + int'(x[11:8]) * 100 + int'(x[7:4]) * 10 + int'(x[3:0]);
    v = (v + 1) % 10000;
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [15:0] rand_bcd();
    return {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
            4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // One clock cycle: drive inputs, advance the model across the coming edge, queue expectations.
  task automatic step(input bit tk);
    bit          se, le, ce, counting, en_n, clr_n;
    int          old;
    logic [15:0] cin;
    exp_t        e;
    @(negedge clk_i);
    cin     = m_cnt;
    rst_i   = r_n;
    tick_i  = tk;
    start_i = bs;
    lap_i   = bl;
    clr_i   = bc;
    cnt_i   = cin;
    en_n    = 1'b0;
    clr_n   = 1'b0;
    if (!r_n) begin
      m_mode = M_IDLE; m_lap = 16'h0; m_keep = 1'b0; m_ovf = 1'b0;
      m_blank = 1'b0; m_bt = 0; h_s = 1'b0; h_l = 1'b0; h_c = 1'b0;
      clr_n = 1'b1;
    end else begin
      se = bs && !h_s;
      le = bl && !h_l;
      ce = bc && !h_c;
      h_s = bs; h_l = bl; h_c = bc;
      old = m_mode;
      counting = (old == M_RUN) || (old == M_SPLIT);
      if (ce) begin
        m_mode = M_IDLE; clr_n = 1'b1; m_lap = 16'h0; m_ovf = 1'b0;
      end else if (se) begin
        m_keep = (old == M_SPLIT);
        m_mode = (old == M_IDLE || old == M_PAUSE) ? M_RUN : M_PAUSE;
      end else if (counting && tk && cin == 16'h9999) begin
        m_ovf = 1'b1; m_keep = (old == M_SPLIT); m_mode = M_PAUSE;
      end else begin
        en_n = counting && tk;
        if (le) begin
          if (old == M_RUN) begin
            m_lap = cin; m_mode = M_SPLIT;
          end else if (old == M_SPLIT) begin
            m_mode = M_RUN;
          end else if (old == M_PAUSE) begin
            m_mode = M_IDLE; clr_n = 1'b1; m_lap = 16'h0; m_ovf = 1'b0;
          end
        end
        if (old == M_PAUSE && m_mode == M_PAUSE && tk) begin
          m_bt++;
          if (m_bt == BLINK) begin
            m_blank = !m_blank;
            m_bt = 0;
          end
        end
      end
      if (m_mode != M_PAUSE) begin
        m_blank = 1'b0;
        m_bt = 0;
      end
    end
    // External BCD counter reacts to the strobes visible during this cycle.
    if (clr_out) m_cnt = 16'h0;
    else if (en_out) m_cnt = bcd_inc(m_cnt);
    en_out  = en_n;
    clr_out = clr_n;
    e.st    = 2'(m_mode);
    e.en    = en_n;
    e.clr   = clr_n;
    e.ovf   = m_ovf;
    e.blank = m_blank;
    e.disp  = (m_mode == M_SPLIT || (m_mode == M_PAUSE && m_keep)) ? m_lap : cin;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  task automatic tick_once();
    step(1'b1);
    idle(2);
  endtask

  task automatic press(input bit s, input bit l, input bit c);
    bs = s; bl = l; bc = c;
    step(1'b0);
    bs = 1'b0; bl = 1'b0; bc = 1'b0;
    step(1'b0);
  endtask

  // Monitor: every edge after the first stimulus presents a full set of outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_i);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("state_o",   16'(state_o),   16'(e.st));
        chk("cnt_en_o",  16'(cnt_en_o),  16'(e.en));
        chk("cnt_clr_o", 16'(cnt_clr_o), 16'(e.clr));
        chk("ovf_o",     16'(ovf_o),     16'(e.ovf));
        chk("blank_o",   16'(blank_o),   16'(e.blank));
        chk("disp_o",    disp_o,         e.disp);
      end
    end
  end

  initial begin
    // Reset.
    r_n = 1'b0;
    idle(3);
    r_n = 1'b1;
    idle(2);

    // Start and count to 0005, then on to 0012.
    press(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tick_once();
    for (int i = 0; i < 7; i++) tick_once();

    // Lap at 0012, three more ticks, lap again back to live display.
    press(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick_once();
    press(1'b0, 1'b1, 1'b0);

    // Pause with blinking, then resume.
    press(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick_once();
    press(1'b1, 1'b0, 1'b0);

    // Saturation at 9999, then clear.
    m_cnt = 16'h9999;
    idle(1);
    tick_once();
    press(1'b0, 1'b0, 1'b1);

    // All three buttons together in RUN, then a held start.
    press(1'b1, 1'b0, 1'b0);
    tick_once();
    press(1'b1, 1'b1, 1'b1);
    bs = 1'b1;
    idle(10);
    bs = 1'b0;
    idle(1);

    // Reset coinciding with a tick while in SPLIT.
    tick_once();
    press(1'b0, 1'b1, 1'b0);
    r_n = 1'b0;
    step(1'b1);
    r_n = 1'b1;
    idle(3);

    // Randomized operation.
    for (int i = 0; i < 3000; i++) begin
      r_n = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 7) == 0) bs = !bs;
      if ($urandom_range(0, 7) == 0) bl = !bl;
      if ($urandom_range(0, 19) == 0) bc = !bc;
      if ($urandom_range(0, 99) == 0) begin
        case ($urandom_range(0, 2))
          0:       m_cnt = 16'h9998;
          1:       m_cnt = 16'h9999;
          default: m_cnt = rand_bcd();
        endcase
      end
      step($urandom_range(0, 3) == 0);
    end
    bs = 1'b0; bl = 1'b0; bc = 1'b0;
    idle(2);

    @(posedge clk_i);
    #2;
    chk("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
